mem_port_arbiter: RTL

Two-requester arbiter that shares the single-port, write-first, 1024-word data/instruction RAM between the instruction-fetch (IF) unit and the load/store unit (LSU) of the RV32I core. It accepts at most one access per cycle and sequences the RAM enable/write controls. It routes the one-cycle-latency read data back to the requester that issued the access. Fixed LSU priority is bounded by a starvation counter, so fetch always makes progress.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the core's memory port: response-owner encoding
// and the byte-to-word address shift.
package mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2
  } own_e;

  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-port instruction/data RAM between IF and LSU: combinational
// grant, starvation-bounded LSU priority, one-cycle response routing.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_gnt,
  output logic                  lsu_rvalid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  own_e       r_owner;
  own_e       w_owner_nxt;
  logic [3:0] r_starve;
  logic       w_if_win;

  // IF takes the port when alone, or when the LSU has hogged it long enough.
  assign w_if_win = if_req && (!lsu_req || (r_starve == LIMIT));
  assign if_gnt   = !rst && w_if_win;
  assign lsu_gnt  = !rst && lsu_req && !w_if_win;

  always_comb begin
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_di      = '0;
    w_owner_nxt = OWN_NONE;
    if (if_gnt) begin
      ram_en      = 1'b1;
      ram_addr    = if_addr >> WORD_SHIFT;
      ram_di      = lsu_wdata;
      w_owner_nxt = OWN_IF;
    end else if (lsu_gnt) begin
      ram_en      = 1'b1;
      ram_we      = lsu_we;
      ram_addr    = lsu_addr >> WORD_SHIFT;
      ram_di      = lsu_wdata;
      w_owner_nxt = OWN_LSU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= OWN_NONE;
      r_starve <= 4'd0;
    end else begin
      r_owner <= w_owner_nxt;
      if (!if_req || if_gnt)
        r_starve <= 4'd0;
      else if (lsu_gnt && (r_starve != LIMIT))
        r_starve <= r_starve + 4'd1;
    end
  end

  // Gated by rst so a response in flight is dropped as soon as reset is seen.
  assign if_rvalid  = !rst && (r_owner == OWN_IF);
  assign lsu_rvalid = !rst && (r_owner == OWN_LSU);
  assign if_rdata   = if_rvalid  ? ram_dout : '0;
  assign lsu_rdata  = lsu_rvalid ? ram_dout : '0;

endmodule
